// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the telemetry framing path (transmit packetizer and receive reconstruction).
package telemetry_pkg;

    localparam int unsigned FIELD_W       = 16;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned PAYLOAD_BYTES = 8;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned FRAME_CNT_W   = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HDR,
        SEND_PAY,
        SEND_CSUM
    } pkt_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] cpu_freq_mhz;
        logic [FIELD_W-1:0] disk_speed_mbps;
        logic [FIELD_W-1:0] memory_usage;
        logic [FIELD_W-1:0] temperature_c;
    } telemetry_rec_t;

    // Payload byte order: field by field, little-endian within each field.
    function automatic logic [BYTE_W-1:0] payload_byte(input telemetry_rec_t rec,
                                                       input logic [IDX_W-1:0] idx);
        logic [FIELD_W-1:0] field;
        case (idx[2:1])
            2'd0:    field = rec.cpu_freq_mhz;
            2'd1:    field = rec.disk_speed_mbps;
            2'd2:    field = rec.memory_usage;
            default: field = rec.temperature_c;
        endcase
        return idx[0] ? field[15:8] : field[7:0];
    endfunction

    // Modulo-256 sum of the payload bytes; the sync byte is not covered.
    function automatic logic [BYTE_W-1:0] payload_checksum(input telemetry_rec_t rec);
        logic [BYTE_W-1:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
            sum = BYTE_W'(sum + payload_byte(rec, IDX_W'(i)));
        end
        return sum;
    endfunction

endpackage

// File: rtl/telemetry_packetizer_if.sv
// Record-in / byte-out bus of the telemetry packetizer.
interface telemetry_packetizer_if;
    import telemetry_pkg::*;

    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [FIELD_W-1:0]     cpu_freq_mhz;
    logic [FIELD_W-1:0]     disk_speed_mbps;
    logic [FIELD_W-1:0]     memory_usage;
    logic [FIELD_W-1:0]     temperature_c;
    logic [BYTE_W-1:0]      data_out;
    logic                   fifo_empty;
    logic                   fifo_read;
    logic                   busy;
    logic [FRAME_CNT_W-1:0] frames_sent;

    modport master (
        output pkt_valid, cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c, fifo_read,
        input  pkt_ready, data_out, fifo_empty, busy, frames_sent
    );

    modport slave (
        input  pkt_valid, cpu_freq_mhz, disk_speed_mbps, memory_usage, temperature_c, fifo_read,
        output pkt_ready, data_out, fifo_empty, busy, frames_sent
    );

endinterface

// File: rtl/telemetry_packetizer.sv
// Frames one telemetry record as SYNC + 8 payload bytes (+ optional checksum) behind a show-ahead pop port.
module telemetry_packetizer
    import telemetry_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    telemetry_packetizer_if.slave bus
);

    pkt_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    telemetry_rec_t         pend_q, pend_d;
    logic                   pend_full_q, pend_full_d;
    telemetry_rec_t         work_q, work_d;
    logic [FRAME_CNT_W-1:0] frames_q, frames_d;
    logic [BYTE_W-1:0]      data_out_q, data_out_d;
    logic                   fifo_empty_q, fifo_empty_d;
    logic                   pkt_ready_q, pkt_ready_d;
    logic                   busy_q, busy_d;

    logic accept_c;
    logic pop_c;
    logic frame_end_c;
    logic load_c;

    assign accept_c = bus.pkt_valid & ~pend_full_q;
    assign pop_c    = bus.fifo_read & (state_q != IDLE);

    // Next-state: frame sequencing, pending hand-off and record capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        work_d      = work_q;
        frames_d    = frames_q;
        frame_end_c = 1'b0;
        load_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_full_q) load_c = 1'b1;
            end
            SEND_HDR: begin
                if (pop_c) begin
                    state_d = SEND_PAY;
                    idx_d   = '0;
                end
            end
            SEND_PAY: begin
                if (pop_c) begin
                    if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
                        if (CHECKSUM_EN) state_d = SEND_CSUM;
                        else             frame_end_c = 1'b1;
                    end else begin
                        idx_d = IDX_W'(idx_q + IDX_W'(1));
                    end
                end
            end
            SEND_CSUM: begin
                if (pop_c) frame_end_c = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (frame_end_c) begin
            frames_d = FRAME_CNT_W'(frames_q + FRAME_CNT_W'(1));
            if (pend_full_q) load_c  = 1'b1;
            else             state_d = IDLE;
        end

        if (load_c) begin
            work_d      = pend_q;
            pend_full_d = 1'b0;
            state_d     = SEND_HDR;
            idx_d       = '0;
        end

        // Accept only happens with pending empty, so it never collides with a load.
        if (accept_c) begin
            pend_d.cpu_freq_mhz    = bus.cpu_freq_mhz;
            pend_d.disk_speed_mbps = bus.disk_speed_mbps;
            pend_d.memory_usage    = bus.memory_usage;
            pend_d.temperature_c   = bus.temperature_c;
            pend_full_d            = 1'b1;
        end
    end

    // Outputs are precomputed from next state so they leave the block registered.
    always_comb begin
        data_out_d = '0;
        case (state_d)
            SEND_HDR:  data_out_d = SYNC_BYTE;
            SEND_PAY:  data_out_d = payload_byte(work_d, idx_d);
            SEND_CSUM: data_out_d = payload_checksum(work_d);
            default:   data_out_d = '0;
        endcase
        fifo_empty_d = (state_d == IDLE);
        pkt_ready_d  = ~pend_full_d;
        busy_d       = (state_d != IDLE) | pend_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            work_q       <= '0;
            frames_q     <= '0;
            data_out_q   <= '0;
            fifo_empty_q <= 1'b1;
            pkt_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            work_q       <= work_d;
            frames_q     <= frames_d;
            data_out_q   <= data_out_d;
            fifo_empty_q <= fifo_empty_d;
            pkt_ready_q  <= pkt_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.fifo_empty  = fifo_empty_q;
    assign bus.pkt_ready   = pkt_ready_q;
    assign bus.busy        = busy_q;
    assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_telemetry_packetizer.sv
// Directed bench for telemetry_packetizer: checksum and no-checksum builds side by side.
module tb_telemetry_packetizer;
    import telemetry_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    telemetry_packetizer_if bus();
    telemetry_packetizer_if bus_nc();

    telemetry_packetizer #(.SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    telemetry_packetizer #(.SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n), .bus(bus_nc.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got [0:31];
    logic        got_rdy [0:31];
    int          got_n;
    bit          gap;
    logic [7:0]  exp_a [0:9];

    // Pops n bytes, recording each byte and pkt_ready at the time it was presented.
    task automatic pop_n(input bit nc, input int n);
        int cyc;
        got_n = 0;
        gap   = 1'b0;
        cyc   = 0;
        while (got_n < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!(nc ? bus_nc.fifo_empty : bus.fifo_empty)) begin
                got[got_n]     = nc ? bus_nc.data_out : bus.data_out;
                got_rdy[got_n] = nc ? bus_nc.pkt_ready : bus.pkt_ready;
                got_n++;
                if (nc) bus_nc.fifo_read = 1'b1; else bus.fifo_read = 1'b1;
            end else begin
                if (nc) bus_nc.fifo_read = 1'b0; else bus.fifo_read = 1'b0;
                if (got_n > 0) gap = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.fifo_read    = 1'b0;
        bus_nc.fifo_read = 1'b0;
    endtask

    // Offers one record; returns #1 after the accepting edge with the fields scrambled.
    task automatic offer(input bit nc, input logic [15:0] c, input logic [15:0] d,
                         input logic [15:0] m, input logic [15:0] t);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (nc) begin
                bus_nc.cpu_freq_mhz = c; bus_nc.disk_speed_mbps = d;
                bus_nc.memory_usage = m; bus_nc.temperature_c = t; bus_nc.pkt_valid = 1'b1;
            end else begin
                bus.cpu_freq_mhz = c; bus.disk_speed_mbps = d;
                bus.memory_usage = m; bus.temperature_c = t; bus.pkt_valid = 1'b1;
            end
            if (nc ? bus_nc.pkt_ready : bus.pkt_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.pkt_valid = 1'b0;       bus_nc.pkt_valid = 1'b0;
        bus.cpu_freq_mhz = 16'hDEAD; bus.disk_speed_mbps = 16'hBEEF;
        bus.memory_usage = 16'h1234; bus.temperature_c = 16'h5A5A;
        bus_nc.cpu_freq_mhz = 16'hDEAD; bus_nc.disk_speed_mbps = 16'hBEEF;
        bus_nc.memory_usage = 16'h1234; bus_nc.temperature_c = 16'h5A5A;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL offer_timeout: record not accepted within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.fifo_empty !== 1'b1)    begin errors++; $display("FAIL reset_fifo_empty got %b exp 1", bus.fifo_empty); end
        checks++; if (bus.data_out !== 8'h00)     begin errors++; $display("FAIL reset_data_out got %h exp 00", bus.data_out); end
        checks++; if (bus.pkt_ready !== 1'b1)     begin errors++; $display("FAIL reset_pkt_ready got %b exp 1", bus.pkt_ready); end
        checks++; if (bus.busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.frames_sent !== 16'd0)  begin errors++; $display("FAIL reset_frames got %0d exp 0", bus.frames_sent); end
        checks++; if (bus_nc.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_nc_fifo_empty got %b exp 1", bus_nc.fifo_empty); end
    endtask

    task automatic test_basic_frame();
        offer(1'b0, 16'd4500, 16'd2000, 16'd16384, 16'd70);
        checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL latency_early got fifo_empty %b exp 1", bus.fifo_empty); end
        checks++; if (bus.busy !== 1'b1)       begin errors++; $display("FAIL pending_busy got %b exp 1", bus.busy); end
        checks++; if (bus.pkt_ready !== 1'b0)  begin errors++; $display("FAIL pending_ready got %b exp 0", bus.pkt_ready); end
        @(posedge clk); #1;
        checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL latency_first got fifo_empty %b exp 0", bus.fifo_empty); end
        checks++; if (bus.data_out !== 8'hA5)  begin errors++; $display("FAIL latency_hdr got %h exp a5", bus.data_out); end
        checks++; if (bus.pkt_ready !== 1'b1)  begin errors++; $display("FAIL loaded_ready got %b exp 1", bus.pkt_ready); end
        pop_n(1'b0, 10);
        checks++; if (got_n != 10) begin errors++; $display("FAIL basic_count got %0d exp 10", got_n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin errors++; $display("FAIL basic_byte[%0d] got %h exp %h", i, got[i], exp_a[i]); end
        end
        checks++; if (bus.frames_sent !== 16'd1) begin errors++; $display("FAIL basic_frames got %0d exp 1", bus.frames_sent); end
        checks++; if (bus.fifo_empty !== 1'b1)   begin errors++; $display("FAIL basic_end_empty got %b exp 1", bus.fifo_empty); end
        checks++; if (bus.data_out !== 8'h00)    begin errors++; $display("FAIL basic_end_data got %h exp 00", bus.data_out); end
        checks++; if (bus.busy !== 1'b0)         begin errors++; $display("FAIL basic_end_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_no_checksum();
        offer(1'b1, 16'd4500, 16'd2000, 16'd16384, 16'd70);
        pop_n(1'b1, 9);
        checks++; if (got_n != 9) begin errors++; $display("FAIL nocsum_count got %0d exp 9", got_n); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin errors++; $display("FAIL nocsum_byte[%0d] got %h exp %h", i, got[i], exp_a[i]); end
        end
        checks++; if (bus_nc.fifo_empty !== 1'b1)  begin errors++; $display("FAIL nocsum_extra_byte fifo_empty %b exp 1", bus_nc.fifo_empty); end
        checks++; if (bus_nc.frames_sent !== 16'd1) begin errors++; $display("FAIL nocsum_frames got %0d exp 1", bus_nc.frames_sent); end
    endtask

    task automatic test_extremes();
        offer(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        pop_n(1'b0, 10);
        checks++; if (got[1] !== 8'hFF) begin errors++; $display("FAIL ones_payload got %h exp ff", got[1]); end
        checks++; if (got[9] !== 8'hF8) begin errors++; $display("FAIL ones_csum got %h exp f8", got[9]); end
        offer(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        pop_n(1'b0, 10);
        checks++; if (got[0] !== 8'hA5) begin errors++; $display("FAIL zeros_hdr got %h exp a5", got[0]); end
        checks++; if (got[9] !== 8'h00) begin errors++; $display("FAIL zeros_csum got %h exp 00", got[9]); end
        checks++; if (bus.frames_sent !== 16'd3) begin errors++; $display("FAIL extremes_frames got %0d exp 3", bus.frames_sent); end
    endtask

    task automatic test_back_to_back();
        offer(1'b0, 16'd4500, 16'd2000, 16'd16384, 16'd70);
        offer(1'b0, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
        checks++; if (bus.pkt_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held got %b exp 0", bus.pkt_ready); end
        checks++; if (bus.busy !== 1'b1)      begin errors++; $display("FAIL b2b_busy got %b exp 1", bus.busy); end
        pop_n(1'b0, 20);
        checks++; if (got_n != 20)        begin errors++; $display("FAIL b2b_count got %0d exp 20", got_n); end
        checks++; if (gap !== 1'b0)       begin errors++; $display("FAIL b2b_gap got %b exp 0", gap); end
        checks++; if (got[9] !== 8'h02)   begin errors++; $display("FAIL b2b_first_csum got %h exp 02", got[9]); end
        checks++; if (got_rdy[9] !== 1'b0) begin errors++; $display("FAIL b2b_ready_first got %b exp 0", got_rdy[9]); end
        checks++; if (got[10] !== 8'hA5)  begin errors++; $display("FAIL b2b_second_hdr got %h exp a5", got[10]); end
        checks++; if (got_rdy[10] !== 1'b1) begin errors++; $display("FAIL b2b_ready_second got %b exp 1", got_rdy[10]); end
        checks++; if (got[11] !== 8'h02)  begin errors++; $display("FAIL b2b_cpu_lsb got %h exp 02", got[11]); end
        checks++; if (got[12] !== 8'h01)  begin errors++; $display("FAIL b2b_cpu_msb got %h exp 01", got[12]); end
        checks++; if (got[18] !== 8'h07)  begin errors++; $display("FAIL b2b_temp_msb got %h exp 07", got[18]); end
        checks++; if (got[19] !== 8'h24)  begin errors++; $display("FAIL b2b_second_csum got %h exp 24", got[19]); end
        checks++; if (bus.frames_sent !== 16'd5) begin errors++; $display("FAIL b2b_frames got %0d exp 5", bus.frames_sent); end
    endtask

    task automatic test_reset_mid_frame();
        offer(1'b0, 16'd4500, 16'd2000, 16'd16384, 16'd70);
        pop_n(1'b0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fifo_empty !== 1'b1)  begin errors++; $display("FAIL midrst_empty got %b exp 1", bus.fifo_empty); end
        checks++; if (bus.frames_sent !== 16'd0) begin errors++; $display("FAIL midrst_frames got %0d exp 0", bus.frames_sent); end
        checks++; if (bus.data_out !== 8'h00)   begin errors++; $display("FAIL midrst_data got %h exp 00", bus.data_out); end
        checks++; if (bus.pkt_ready !== 1'b1)   begin errors++; $display("FAIL midrst_ready got %b exp 1", bus.pkt_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.fifo_empty !== 1'b1)  begin errors++; $display("FAIL midrst_resume got fifo_empty %b exp 1", bus.fifo_empty); end
        offer(1'b0, 16'd4500, 16'd2000, 16'd16384, 16'd70);
        pop_n(1'b0, 10);
        checks++; if (got_n != 10) begin errors++; $display("FAIL midrst_count got %0d exp 10", got_n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin errors++; $display("FAIL midrst_byte[%0d] got %h exp %h", i, got[i], exp_a[i]); end
        end
        checks++; if (bus.frames_sent !== 16'd1) begin errors++; $display("FAIL midrst_frames_after got %0d exp 1", bus.frames_sent); end
    endtask

    task automatic test_read_while_empty();
        int bad;
        bad = 0;
        bus.fifo_read = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.fifo_empty !== 1'b1 || bus.busy !== 1'b0 || bus.data_out !== 8'h00) bad++;
        end
        bus.fifo_read = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_read_disturb got %0d bad cycles exp 0", bad); end
        checks++; if (bus.frames_sent !== 16'd1) begin errors++; $display("FAIL idle_read_frames got %0d exp 1", bus.frames_sent); end
        offer(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        pop_n(1'b0, 10);
        checks++; if (got_n != 10)      begin errors++; $display("FAIL idle_read_count got %0d exp 10", got_n); end
        checks++; if (got[0] !== 8'hA5) begin errors++; $display("FAIL idle_read_hdr got %h exp a5", got[0]); end
        checks++; if (got[9] !== 8'hF8) begin errors++; $display("FAIL idle_read_csum got %h exp f8", got[9]); end
        checks++; if (bus.frames_sent !== 16'd2) begin errors++; $display("FAIL idle_read_frames_after got %0d exp 2", bus.frames_sent); end
    endtask

    initial begin
        exp_a = '{8'hA5, 8'h94, 8'h11, 8'hD0, 8'h07, 8'h00, 8'h40, 8'h46, 8'h00, 8'h02};
        bus.pkt_valid = 1'b0;    bus.fifo_read = 1'b0;
        bus.cpu_freq_mhz = '0;   bus.disk_speed_mbps = '0;
        bus.memory_usage = '0;   bus.temperature_c = '0;
        bus_nc.pkt_valid = 1'b0; bus_nc.fifo_read = 1'b0;
        bus_nc.cpu_freq_mhz = '0; bus_nc.disk_speed_mbps = '0;
        bus_nc.memory_usage = '0; bus_nc.temperature_c = '0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_basic_frame();
        test_no_checksum();
        test_extremes();
        test_back_to_back();
        test_reset_mid_frame();
        test_read_while_empty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
